// File: rtl/dm_arbiter_if.sv
// ---------------------------------------------------------------------------
// dm_arbiter_if
// Bundles the three request/response groups around the data-memory arbiter:
//   pipeline MEM stage : p_rd, p_wr, p_addr, p_wdata -> p_stall, p_done, p_rdata
//   loader/debug port  : l_req, l_wr, l_addr, l_wdata -> l_done, l_rdata
//   single-port DM     : dm_rd, dm_wr, dm_addr, dm_wdata <- dm_rdata
// Modports:
//   slave  : the arbiter's view (takes requests, drives the DM)
//   master : the surrounding system's view (pipeline, loader and DM model)
// ---------------------------------------------------------------------------
interface dm_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    // Pipeline MEM stage
    logic                  p_rd;
    logic                  p_wr;
    logic [ADDR_WIDTH-1:0] p_addr;
    logic [DATA_WIDTH-1:0] p_wdata;
    logic                  p_stall;
    logic                  p_done;
    logic [DATA_WIDTH-1:0] p_rdata;

    // Loader / debug port
    logic                  l_req;
    logic                  l_wr;
    logic [ADDR_WIDTH-1:0] l_addr;
    logic [DATA_WIDTH-1:0] l_wdata;
    logic                  l_done;
    logic [DATA_WIDTH-1:0] l_rdata;

    // Single-port data memory
    logic                  dm_rd;
    logic                  dm_wr;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0] dm_wdata;
    logic [DATA_WIDTH-1:0] dm_rdata;

    modport slave (
        input  p_rd, p_wr, p_addr, p_wdata,
        output p_stall, p_done, p_rdata,
        input  l_req, l_wr, l_addr, l_wdata,
        output l_done, l_rdata,
        output dm_rd, dm_wr, dm_addr, dm_wdata,
        input  dm_rdata
    );

    modport master (
        output p_rd, p_wr, p_addr, p_wdata,
        input  p_stall, p_done, p_rdata,
        output l_req, l_wr, l_addr, l_wdata,
        input  l_done, l_rdata,
        input  dm_rd, dm_wr, dm_addr, dm_wdata,
        output dm_rdata
    );
endinterface

// File: rtl/dm_arbiter.sv
// ---------------------------------------------------------------------------
// dm_arbiter
// Shares one single-port data memory between the CPU pipeline MEM stage and a
// loader/debug port. One access is in flight at a time, sequenced by an
// IDLE -> CMD -> (WAIT x RD_LAT) -> RESP state machine. The pipeline has
// priority; a pipeline request with both p_rd and p_wr set is a write.
//
// Ports:
//   clk    in   single clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of dm_arbiter_if (pipeline, loader and DM groups)
//   busy   out  high whenever the state machine is not in IDLE
//
// Parameters: DATA_WIDTH, ADDR_WIDTH, RD_LAT (DM read latency, 1..4),
//             STARVE_MAX (pipeline grants before the loader is forced in).
//
// Build option: define DM_ARB_STARVE_GUARD_EN to enable the loader starvation
// guard. Without it the loader is only served in IDLE cycles that carry no
// pipeline request.
// ---------------------------------------------------------------------------
module dm_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    dm_arbiter_if.slave bus,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} stateT;

    // Counts RD_LAT-1 down to 0; three bits cover the legal RD_LAT range.
    localparam int WAIT_W = 3;

    stateT                 state;
    logic                  ownerLoader;   // owner of the access in flight
    logic                  isWrite;
    logic [WAIT_W-1:0]     waitCnt;

    logic                  pReq;
    logic                  anyReq;
    logic                  grantLoader;
    logic                  forceLoader;
    logic                  reqWrite;
    logic [ADDR_WIDTH-1:0] reqAddr;
    logic [DATA_WIDTH-1:0] reqWdata;

`ifdef DM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    // Pipeline grants taken while the loader kept waiting.
    logic [CNT_W-1:0] starveCnt;

    assign forceLoader = bus.l_req && (starveCnt == CNT_W'(STARVE_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starveCnt <= '0;
        end else if (!bus.l_req) begin
            starveCnt <= '0;
        end else if (state == IDLE && anyReq) begin
            starveCnt <= grantLoader ? '0 : starveCnt + 1'b1;
        end
    end
`else
    assign forceLoader = 1'b0;
`endif

    // Winner selection for the IDLE cycle.
    // NOTE: every signal gets a value on every path through always_comb;
    // a missing assignment would infer a latch.
    always_comb begin
        pReq        = bus.p_rd | bus.p_wr;
        anyReq      = pReq | bus.l_req;
        grantLoader = bus.l_req & (~pReq | forceLoader);
        // p_rd together with p_wr falls through to a write.
        reqWrite    = grantLoader ? bus.l_wr    : bus.p_wr;
        reqAddr     = grantLoader ? bus.l_addr  : bus.p_addr;
        reqWdata    = grantLoader ? bus.l_wdata : bus.p_wdata;
    end

    // The pipeline is released only in the response cycle of its own access;
    // a loader access in flight holds it off just by occupying the DM.
    assign bus.p_stall = pReq & ~((state == RESP) & ~ownerLoader);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            ownerLoader  <= 1'b0;
            isWrite      <= 1'b0;
            waitCnt      <= '0;
            bus.dm_rd    <= 1'b0;
            bus.dm_wr    <= 1'b0;
            bus.dm_addr  <= '0;
            bus.dm_wdata <= '0;
            bus.p_done   <= 1'b0;
            bus.l_done   <= 1'b0;
            bus.p_rdata  <= '0;
            bus.l_rdata  <= '0;
        end else begin
            // Strobes are single-cycle; the states below raise them as needed.
            bus.dm_rd  <= 1'b0;
            bus.dm_wr  <= 1'b0;
            bus.p_done <= 1'b0;
            bus.l_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (anyReq) begin
                        ownerLoader  <= grantLoader;
                        isWrite      <= reqWrite;
                        bus.dm_addr  <= reqAddr;
                        bus.dm_wdata <= reqWdata;
                        // Command strobe is registered so it lands in CMD.
                        bus.dm_rd    <= ~reqWrite;
                        bus.dm_wr    <= reqWrite;
                        busy         <= 1'b1;
                        state        <= CMD;
                    end
                end

                CMD: begin
                    if (isWrite) begin
                        bus.p_done <= ~ownerLoader;
                        bus.l_done <= ownerLoader;
                        state      <= RESP;
                    end else begin
                        waitCnt <= WAIT_W'(RD_LAT - 1);
                        state   <= WAIT;
                    end
                end

                WAIT: begin
                    if (waitCnt == '0) begin
                        // DM data is valid in the last WAIT cycle.
                        if (ownerLoader) begin
                            bus.l_rdata <= bus.dm_rdata;
                        end else begin
                            bus.p_rdata <= bus.dm_rdata;
                        end
                        bus.p_done <= ~ownerLoader;
                        bus.l_done <= ownerLoader;
                        state      <= RESP;
                    end else begin
                        waitCnt <= waitCnt - 1'b1;
                    end
                end

                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dm_arbiter
// Drives dm_arbiter through dm_arbiter_if with directed scenarios and random
// pipeline/loader traffic. A DM model with a true RD_LAT read latency sits on
// the memory side. Expected behaviour comes from a transaction-level model:
// each granted access is given a command cycle and a done cycle by plain
// latency arithmetic, and a reference memory supplies the read data.
// Define DM_ARB_STARVE_GUARD_EN for both RTL and bench to test the guard.
// ---------------------------------------------------------------------------
module tb_dm_arbiter;
    localparam int DW         = 16;
    localparam int AW         = 8;
    localparam int RD_LAT     = 2;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dm_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RD_LAT    (RD_LAT),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .busy (busy)
    );

    // Data memory: read data is valid only in the cycle RD_LAT after dm_rd.
    logic [DW-1:0] dmMem [256] = '{default: '0};
    int rdAge = 0;

    always @(posedge clk) begin
        if (bus.dm_wr) dmMem[bus.dm_addr] <= bus.dm_wdata;
        rdAge <= bus.dm_rd ? 1 : ((rdAge > 0 && rdAge < 8) ? rdAge + 1 : 0);
    end

    assign bus.dm_rdata = (rdAge == RD_LAT) ? dmMem[bus.dm_addr] : 16'hDEAD;

    // Transaction-level reference model
    int            cyc = 0;
    int            nextIdle, cmdAt, doneAt, starve;
    bit            curLoader, curWrite;
    logic [AW-1:0] curAddr, dmAddrExp;
    logic [DW-1:0] curWdata, readVal, pRdExp, lRdExp, dmWdataExp;
    logic [DW-1:0] refMem [256] = '{default: '0};
    bit            pDonePrev, lDonePrev;
    int            pDoneCnt, lDoneCnt, pBeforeL, dmRdCnt, lastPDone, lastLDone;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic void resetModel();
        nextIdle   = cyc;
        cmdAt      = -100;
        doneAt     = -100;
        starve     = 0;
        pRdExp     = '0;
        lRdExp     = '0;
        dmAddrExp  = '0;
        dmWdataExp = '0;
        pDonePrev  = 1'b0;
        lDonePrev  = 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic setPipe(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.p_rd    = rd;
        bus.p_wr    = wr;
        bus.p_addr  = a;
        bus.p_wdata = d;
    endtask

    task automatic setLoader(input bit req, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.l_req   = req;
        bus.l_wr    = wr;
        bus.l_addr  = a;
        bus.l_wdata = d;
    endtask

    // Requesters: the pipeline moves on after p_done or when it has no memory
    // op; the loader drops its request for one cycle after l_done.
    task automatic drive(input int pPct, input int lPct, input bit rdOnly);
        int k;
        if (pDonePrev || !(bus.p_rd || bus.p_wr)) begin
            if ($urandom_range(0, 99) < pPct) begin
                k = rdOnly ? 1 : $urandom_range(1, 3);
                setPipe(k[0], k[1], AW'($urandom_range(0, 15)), DW'($urandom));
            end else begin
                setPipe(1'b0, 1'b0, '0, '0);
            end
        end
        if (lDonePrev) begin
            setLoader(1'b0, 1'b0, '0, '0);
        end else if (!bus.l_req && $urandom_range(0, 99) < lPct) begin
            setLoader(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
        end
    endtask

    // Advance the model by one cycle and compare every output.
    task automatic evalCycle();
        bit pReq, lWin;
        #1;
        pReq = bus.p_rd || bus.p_wr;
        if (!bus.l_req) starve = 0;
        if (cyc >= nextIdle && (pReq || bus.l_req)) begin
            lWin = bus.l_req && !pReq;
`ifdef DM_ARB_STARVE_GUARD_EN
            if (bus.l_req && starve >= STARVE_MAX) lWin = 1'b1;
`endif
            curLoader = lWin;
            curWrite  = lWin ? bus.l_wr    : bus.p_wr;
            curAddr   = lWin ? bus.l_addr  : bus.p_addr;
            curWdata  = lWin ? bus.l_wdata : bus.p_wdata;
            cmdAt     = cyc + 1;
            doneAt    = cyc + (curWrite ? 2 : 2 + RD_LAT);
            nextIdle  = doneAt + 1;
            if (lWin) starve = 0;
            else if (bus.l_req) starve++;
        end
        if (cyc == cmdAt) begin
            dmAddrExp  = curAddr;
            dmWdataExp = curWdata;
            if (curWrite) refMem[curAddr] = curWdata;
            else readVal = refMem[curAddr];
        end
        if (cyc == doneAt && !curWrite) begin
            if (curLoader) lRdExp = readVal;
            else pRdExp = readVal;
        end

        check("dm_rd",    bus.dm_rd,    cyc == cmdAt && !curWrite);
        check("dm_wr",    bus.dm_wr,    cyc == cmdAt && curWrite);
        check("dm_addr",  bus.dm_addr,  dmAddrExp);
        check("dm_wdata", bus.dm_wdata, dmWdataExp);
        check("p_done",   bus.p_done,   cyc == doneAt && !curLoader);
        check("l_done",   bus.l_done,   cyc == doneAt && curLoader);
        check("p_rdata",  bus.p_rdata,  pRdExp);
        check("l_rdata",  bus.l_rdata,  lRdExp);
        check("p_stall",  bus.p_stall,  pReq && !(cyc == doneAt && !curLoader));
        check("busy",     busy,         cyc >= cmdAt && cyc <= doneAt);

        pDonePrev = bus.p_done;
        lDonePrev = bus.l_done;
        if (bus.p_done) begin
            pDoneCnt++;
            lastPDone = cyc;
        end
        if (bus.l_done) begin
            if (lDoneCnt == 0) pBeforeL = pDoneCnt;
            lDoneCnt++;
            lastLDone = cyc;
        end
        if (bus.dm_rd) dmRdCnt++;
    endtask

    task automatic step(input int pPct, input int lPct, input bit rdOnly);
        drive(pPct, lPct, rdOnly);
        evalCycle();
        tick();
    endtask

    // Asserts reset mid-cycle, checks the immediate effect, releases it just
    // after a rising edge so the following cycle is an IDLE cycle.
    task automatic doReset();
        rst_n = 1'b0;
        #1;
        check("rst dm_rd",    bus.dm_rd,    1'b0);
        check("rst dm_wr",    bus.dm_wr,    1'b0);
        check("rst dm_addr",  bus.dm_addr,  '0);
        check("rst dm_wdata", bus.dm_wdata, '0);
        check("rst p_rdata",  bus.p_rdata,  '0);
        check("rst l_rdata",  bus.l_rdata,  '0);
        check("rst p_done",   bus.p_done,   1'b0);
        check("rst l_done",   bus.l_done,   1'b0);
        check("rst busy",     busy,         1'b0);
        repeat (2) begin
            tick();
            check("rst hold p_done", bus.p_done, 1'b0);
            check("rst hold busy",   busy,       1'b0);
        end
        rst_n = 1'b1;
        resetModel();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst_n = 1'b1;
        setPipe(1'b0, 1'b0, '0, '0);
        setLoader(1'b0, 1'b0, '0, '0);
        #3;
        doReset();

        // Pipeline write: command in cycle 1, done in cycle 2.
        setPipe(1'b0, 1'b1, 8'h10, 16'h1234);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1'b0);
            evalCycle();
            if (k == 0) check("wr stall c0", bus.p_stall, 1'b1);
            if (k == 1) begin
                check("wr dm_wr c1",    bus.dm_wr,    1'b1);
                check("wr dm_addr c1",  bus.dm_addr,  8'h10);
                check("wr dm_wdata c1", bus.dm_wdata, 16'h1234);
                check("wr stall c1",    bus.p_stall,  1'b1);
            end
            if (k == 2) begin
                check("wr p_done c2", bus.p_done,  1'b1);
                check("wr stall c2",  bus.p_stall, 1'b0);
            end
            tick();
        end
        repeat (2) step(0, 0, 1'b0);

        // Seed 0x20 with 0xBEEF, then read it back with cycle-exact checks.
        setPipe(1'b0, 1'b1, 8'h20, 16'hBEEF);
        repeat (5) step(0, 0, 1'b0);
        setPipe(1'b1, 1'b0, 8'h20, 16'h0000);
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 1'b0);
            evalCycle();
            if (k <= 3) check("rd stall", bus.p_stall, 1'b1);
            if (k == 1) check("rd dm_rd c1", bus.dm_rd, 1'b1);
            if (k == 4) begin
                check("rd p_done c4",  bus.p_done,  1'b1);
                check("rd p_rdata c4", bus.p_rdata, 16'hBEEF);
                check("rd stall c4",   bus.p_stall, 1'b0);
            end
            tick();
        end
        repeat (2) step(0, 0, 1'b0);

        // Simultaneous pipeline read and loader write: pipeline goes first.
        lastPDone = -1000;
        lastLDone = -1000;
        setPipe(1'b1, 1'b0, 8'h20, 16'h0000);
        setLoader(1'b1, 1'b1, 8'h05, 16'h00AA);
        repeat (12) step(0, 0, 1'b0);
        check("both loader after pipe", lastLDone - lastPDone, 3);
        check("both dm[05]", dmMem[8'h05], 16'h00AA);

        // Read plus write together is a write; p_rdata keeps 0xBEEF.
        dmRdCnt = 0;
        setPipe(1'b1, 1'b1, 8'h30, 16'h7777);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1'b0);
            evalCycle();
            if (k == 1) check("rdwr dm_wr c1", bus.dm_wr, 1'b1);
            tick();
        end
        repeat (2) step(0, 0, 1'b0);
        check("rdwr no dm_rd", dmRdCnt, 0);
        check("rdwr p_rdata",  bus.p_rdata, 16'hBEEF);
        check("rdwr dm[30]",   dmMem[8'h30], 16'h7777);

        // Reset in the first WAIT cycle of a pipeline read; the held read
        // must then restart from IDLE and complete with its full latency.
        setPipe(1'b1, 1'b0, 8'h05, 16'h0000);
        repeat (2) step(0, 0, 1'b0);
        drive(0, 0, 1'b0);
        evalCycle();
        #2;
        doReset();
        t0 = cyc;
        lastPDone = -1000;
        repeat (8) step(0, 0, 1'b0);
        check("rst restart latency", lastPDone - t0, 2 + RD_LAT);
        check("rst restart p_rdata", bus.p_rdata, 16'h00AA);

        // Random mixed traffic from both requesters.
        repeat (1500) step(60, 30, 1'b0);
        repeat (30) step(0, 0, 1'b0);

        // Continuous pipeline reads with the loader always requesting.
        doReset();
        pDoneCnt = 0;
        lDoneCnt = 0;
        pBeforeL = -1;
        setPipe(1'b1, 1'b0, 8'h05, 16'h0000);
        setLoader(1'b1, 1'b0, 8'h10, 16'h0000);
        repeat (60) step(100, 100, 1'b1);
`ifdef DM_ARB_STARVE_GUARD_EN
        check("starve pipe grants before loader", pBeforeL, STARVE_MAX);
        check("starve loader served", lDoneCnt > 0, 1'b1);
`else
        check("starve loader locked out", lDoneCnt, 0);
`endif
        check("starve pipeline progress", pDoneCnt > 8, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
